// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent set/reset flip-flops with registered complement,
// per-cycle conflict flag, saturating conflict counter and per-bit change flags.
module sr_ff_bank #(
  parameter int                 WIDTH         = 8,
  parameter int                 CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0]   RESET_VALUE   = '0,
  parameter int                 CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic [WIDTH-1:0] changed
);

  // Out-of-range modes fall back to hold.
  localparam int MODE = (CONFLICT_MODE < 0 || CONFLICT_MODE > 3) ? 0 : CONFLICT_MODE;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qb;
  logic [WIDTH-1:0] r_changed;
  logic             r_conflict;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_q_next;
  logic             w_conflict;
  logic             w_cnt_sat;

  assign w_conflict = en & (|(s & r));
  assign w_cnt_sat  = (r_cnt == {CNT_W{1'b1}});

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_q_next = r_q;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case ({s[i], r[i]})
          2'b10: w_q_next[i] = 1'b1;
          2'b01: w_q_next[i] = 1'b0;
          2'b11: begin
            if (MODE == 1)      w_q_next[i] = 1'b1;
            else if (MODE == 2) w_q_next[i] = 1'b0;
            else if (MODE == 3) w_q_next[i] = ~r_q[i];
            else                w_q_next[i] = r_q[i];
          end
          default: w_q_next[i] = r_q[i];
        endcase
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q        <= RESET_VALUE;
      r_qb       <= ~RESET_VALUE;
      r_changed  <= '0;
      r_conflict <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_q        <= w_q_next;
      r_qb       <= ~w_q_next;
      r_changed  <= en ? (w_q_next ^ r_q) : '0;
      r_conflict <= w_conflict;
      if (clr_cnt)
        r_cnt <= '0;
      else if (w_conflict && !w_cnt_sat)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign q            = r_q;
  assign qb           = r_qb;
  assign changed      = r_changed;
  assign conflict     = r_conflict;
  assign conflict_cnt = r_cnt;

endmodule
